mcse_ami_outbox: RTL
====================

MCSE_AMI_OUTBOX -- requirements
Module: mcse_ami_outbox

Interface
REQ-001 SHALL have parameter NUM_CH, default 4; number of producer channels, 2..16.
REQ-002 SHALL have parameter AMI_WIDTH, default 256; message word width.
REQ-003 SHALL have parameter DEPTH, default 4; FIFO depth, power of two, at least 2.
REQ-004 SHALL derive CH_W = clog2(NUM_CH) and CW = clog2(DEPTH)+1.
REQ-005 SHALL have port clk, input, 1; the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1; reset, synchronous, active-low.
REQ-007 SHALL have port ch_valid, input, NUM_CH; per-channel message valid.
REQ-008 SHALL have port ch_data, input, NUM_CH*AMI_WIDTH; channel i occupies bits [i*AMI_WIDTH +: AMI_WIDTH].
REQ-009 SHALL have port ch_enable, input, NUM_CH; per-channel arbitration mask.
REQ-010 SHALL have port ch_ready, output, NUM_CH; one-hot or zero grant.
REQ-011 SHALL have port flush, input, 1; discard all queued words.
REQ-012 SHALL have port ami_out, output, AMI_WIDTH; presented message.
REQ-013 SHALL have port ami_ch, output, CH_W; source channel of ami_out.
REQ-014 SHALL have port ami_valid, output, 1; message present.
REQ-015 SHALL have port ami_ack, input, 1; consumer acknowledge, level.
REQ-016 SHALL have port count, output, CW; FIFO occupancy, output register excluded.
REQ-017 SHALL have port tx_cnt, output, 16; completed handshakes, wraps 0xFFFF->0.

Function
REQ-018 SHALL make ch_ready combinational: only the round-robin winner among (ch_valid & ch_enable) is set, and only when count<DEPTH and flush=0.
REQ-019 SHALL start the round-robin search at pointer rr (0..NUM_CH-1) and search upward with wrap to 0.
REQ-020 SHALL, when ch_valid[i] & ch_ready[i], write {i, ch_data[i]} to the FIFO tail and set rr to (i+1) mod NUM_CH; rr SHALL otherwise hold.
REQ-021 SHALL accept at most one word per cycle and SHALL never drop an accepted word except on flush or reset.
REQ-022 SHALL run an output FSM with states IDLE, PRESENT and RELEASE.
REQ-023 IDLE: if count>0, SHALL pop the head into the ami_out/ami_ch register and go to PRESENT; otherwise SHALL stay in IDLE.
REQ-024 PRESENT: ami_valid=1 with ami_out/ami_ch stable; on ami_ack=1 SHALL increment tx_cnt and go to RELEASE.
REQ-025 RELEASE: ami_valid=0; on ami_ack=0 SHALL go to IDLE.
REQ-026 SHALL give ami_valid=1 only in PRESENT; ami_out and ami_ch SHALL hold their last value outside PRESENT.
REQ-027 SHALL give latency from accept (edge E) to ami_valid=1 of 2 cycles when the FSM is IDLE and the FIFO is empty.
REQ-028 SHALL, when push and pop occur in the same cycle, leave count unchanged and handle both correctly.
REQ-029 SHALL compute full as count==DEPTH, with no pass-through; when full, ch_ready SHALL be all 0.
REQ-030 SHALL, on flush=1, set count to 0 and the pointers to 0 at that edge, with no push and no IDLE pop that cycle.
REQ-031 SHALL NOT let flush disturb PRESENT or RELEASE; an in-flight word SHALL complete its handshake.
REQ-032 SHALL treat a channel whose ch_enable is 0 as never granted; its ch_valid SHALL be ignored.

Reset
REQ-033 SHALL, on rst=0 at a clk edge, set FSM=IDLE, rr=0, FIFO pointers=0, count=0, tx_cnt=0, ami_valid=0, ami_out=0, ami_ch=0.
REQ-034 SHALL hold ch_ready=0 while rst=0, and a reset mid-handshake SHALL abandon the word.

Verification
REQ-035 Reset, then ch_valid=0001, data=0xA5 at edge 0 -> ami_valid=1 at cycle 2 with ami_out=0xA5 and ami_ch=0; ack high then low -> tx_cnt=1, back in IDLE.
REQ-036 ch_valid=1111 held, ch_enable=1111, ami_ack=0 -> grants in order ch0,ch1,ch2,ch3, then ch_ready=0000 with count=4 and ami_out from ch0 presented (one word popped, then full again after ch0's refill).
REQ-037 ch_enable=1010, ch_valid=1111 -> only ch1 and ch3 are granted, alternating.
REQ-038 Keep ami_ack=1 continuously -> the second word is not presented until ami_ack=0, then IDLE, then PRESENT.
REQ-039 With count=3 and PRESENT, pulse flush -> count=0 next cycle, the presented word still completes, tx_cnt+1, and no further ami_valid.
REQ-040 Assert rst=0 during PRESENT with count=2 -> all outputs and count return to 0 at the next edge.

Source files
------------

// File: rtl/mcse_ami_outbox.sv
// rtl/mcse_ami_outbox.sv - Round-robin multi-channel message outbox with FIFO and level-ack output FSM
// Channels are arbitrated into a small FIFO; the head is presented on ami_out under a 4-phase handshake.
module mcse_ami_outbox #(
  parameter  int NUM_CH    = 4,
  parameter  int AMI_WIDTH = 256,
  parameter  int DEPTH     = 4,
  localparam int CH_W      = $clog2(NUM_CH),
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           ch_valid,
  input  logic [NUM_CH*AMI_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]           ch_enable,
  output logic [NUM_CH-1:0]           ch_ready,
  input  logic                        flush,
  output logic [AMI_WIDTH-1:0]        ami_out,
  output logic [CH_W-1:0]             ami_ch,
  output logic                        ami_valid,
  input  logic                        ami_ack,
  output logic [CW-1:0]               count,
  output logic [15:0]                 tx_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = CH_W + AMI_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       rr_q, rr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [15:0]           tx_cnt_q, tx_cnt_d;
  logic [AMI_WIDTH-1:0]  ami_out_q, ami_out_d;
  logic [CH_W-1:0]       ami_ch_q, ami_ch_d;
  logic [EW-1:0]         mem_q [DEPTH];

  logic [NUM_CH-1:0]     req;
  logic                  win_found;
  logic [CH_W-1:0]       win_idx;
  int                    scan_idx;
  logic                  can_push;
  logic                  push;
  logic                  pop;
  logic [EW-1:0]         head;

  // Rotating priority search starting at rr, wrapping past the top channel.
  always_comb begin
    req       = ch_valid & ch_enable;
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = int'(rr_q) + k;
      if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = CH_W'(scan_idx);
      end
    end
  end

  // Grant is masked by reset so no word can be captured while the block is held.
  always_comb begin
    can_push = rst && !flush && (count_q < CW'(DEPTH));
    ch_ready = '0;
    if (can_push && win_found) ch_ready[win_idx] = 1'b1;
    push = |ch_ready;
  end

  always_comb begin
    rr_d = rr_q;
    if (push) rr_d = (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + CH_W'(1);
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    ami_out_d = ami_out_q;
    ami_ch_d  = ami_ch_q;
    tx_cnt_d  = tx_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!flush && (count_q != '0)) begin
          pop       = 1'b1;
          ami_out_d = head[AMI_WIDTH-1:0];
          ami_ch_d  = head[EW-1 -: CH_W];
          state_d   = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (ami_ack) begin
          tx_cnt_d = tx_cnt_q + 16'd1;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!ami_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_cnt_q  <= '0;
      ami_out_q <= '0;
      ami_ch_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_cnt_q  <= tx_cnt_d;
      ami_out_q <= ami_out_d;
      ami_ch_q  <= ami_ch_d;
    end
  end

  // Storage needs no reset: occupancy tracking decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {win_idx, ch_data[win_idx*AMI_WIDTH +: AMI_WIDTH]};
  end

  assign ami_valid = (state_q == S_PRESENT);
  assign ami_out   = ami_out_q;
  assign ami_ch    = ami_ch_q;
  assign count     = count_q;
  assign tx_cnt    = tx_cnt_q;

endmodule
